dot_matrix_frame_ctrl: RTL and testbench

- Controller for the 8x8 dot-matrix scan datapath.
- Holds a double-buffered 8-row frame: a writer fills the back buffer over a valid/ready port, then requests a commit.
- The front buffer is swapped only at a frame boundary, so the display never shows a half-written frame.
- Continuously scans rows onto dot_row/dot_col and replaces hard-coded per-row pattern tables.

---
 rtl/dotm_pkg.sv | 26 ++
 rtl/dot_matrix_row_scanner.sv | 50 +++++
 rtl/dot_matrix_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_dot_matrix_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotm_pkg.sv
// Shared types and helpers for the 8x8 dot-matrix frame controller.
// Geometry constants, row-select encoder and frame FSM states.
package dotm_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = $clog2(ROWS);

    typedef logic [ROW_W-1:0] row_idx_t;
    typedef logic [COLS-1:0]  col_t;
    typedef logic [ROWS-1:0]  row_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } frame_state_t;

    // Active-low one-hot row select; row 0 is the MSB.
    function automatic row_sel_t row_sel(input row_idx_t idx);
        row_sel_t top;
        top = row_sel_t'({1'b1, {(ROWS-1){1'b0}}});
        return ~(top >> idx);
    endfunction

endpackage

// File: rtl/dot_matrix_row_scanner.sv
// Row scan timing: dwell counter and row index for the dot matrix.
// Outputs describe the scan position the next clock edge will display.
//
// Ports:
//   clock_div   scan clock
//   reset       asynchronous, active-low
//   row_idx     row to be shown after the next edge
//   row_last    next edge shows the last dwell cycle of row 7
//   blank       next edge falls in the blanking part of the dwell
//   frame_start next edge shows the first cycle of row 0
module dot_matrix_row_scanner
    import dotm_pkg::*;
#(
    parameter int unsigned ROW_DWELL    = 1,
    parameter int unsigned BLANK_CYCLES = 0
) (
    input  logic     clock_div,
    input  logic     reset,
    output row_idx_t row_idx,
    output logic     row_last,
    output logic     blank,
    output logic     frame_start
);

    localparam logic [7:0] DWELL_LAST = 8'(ROW_DWELL - 1);
    localparam logic [8:0] BLANK_N    = 9'(BLANK_CYCLES);
    localparam row_idx_t   ROW_LAST   = row_idx_t'(ROWS - 1);

    logic [7:0] dwell;
    row_idx_t   row;

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            dwell <= '0;
            row   <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            row   <= row + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign row_idx     = row;
    assign row_last    = (row == ROW_LAST) && (dwell == DWELL_LAST);
    // dwell < BLANK_CYCLES, written so a zero blank count stays well-formed
    assign blank       = ({1'b0, dwell} + 9'd1) <= BLANK_N;
    assign frame_start = (row == '0) && (dwell == '0);

endmodule

// File: rtl/dot_matrix_frame_ctrl.sv
// Double-buffered 8x8 dot-matrix frame controller.
// Back buffer is written by the host; front swaps only at frame boundaries.
//
// Ports:
//   clock_div   scan clock (already divided)
//   reset       asynchronous, active-low
//   wr_valid    host row write request
//   wr_ready    back buffer accepts writes (IDLE only)
//   wr_row      target row, 0 = top
//   wr_data     column pattern, bit7 = leftmost
//   commit      request back-to-front swap
//   commit_ack  pulse with the first row 0 of the new frame
//   frame_start pulse whenever row 0 is first driven
//   dot_row     active-low one-hot row select
//   dot_col     active-high column data
module dot_matrix_frame_ctrl
    import dotm_pkg::*;
#(
    parameter int unsigned ROW_DWELL    = 1,
    parameter int unsigned BLANK_CYCLES = 0
) (
    input  logic       clock_div,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       commit_ack,
    output logic       frame_start,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col
);

    col_t         back_buf  [ROWS];
    col_t         front_buf [ROWS];
    frame_state_t state;
    frame_state_t state_nxt;

    row_idx_t scan_row;
    logic     scan_last;
    logic     scan_blank;
    logic     scan_fs;

    logic wr_fire;
    col_t col_src;
    col_t col_nxt;

    dot_matrix_row_scanner #(
        .ROW_DWELL   (ROW_DWELL),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan (
        .clock_div  (clock_div),
        .reset      (reset),
        .row_idx    (scan_row),
        .row_last   (scan_last),
        .blank      (scan_blank),
        .frame_start(scan_fs)
    );

    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SWAP is entered while row 7's last dwell is on the display,
    // so the edge leaving SWAP is always the new frame's row 0.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (commit) state_nxt = PENDING;
            PENDING: if (scan_last) state_nxt = SWAP;
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Row 0 of the new frame must show back data in the same
    // edge that copies back into front.
    always_comb begin
        col_src = front_buf[scan_row];
        if (state == SWAP) begin
            col_src = back_buf[scan_row];
        end
        col_nxt = scan_blank ? '0 : col_src;
    end

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                back_buf[i]  <= '0;
                front_buf[i] <= '0;
            end
        end else begin
            if (wr_fire) begin
                back_buf[wr_row] <= wr_data;
            end
            if (state == SWAP) begin
                for (int i = 0; i < ROWS; i++) begin
                    front_buf[i] <= back_buf[i];
                end
            end
        end
    end

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            dot_row     <= '0;
            dot_col     <= '0;
            frame_start <= 1'b0;
            commit_ack  <= 1'b0;
            wr_ready    <= 1'b0;
        end else begin
            dot_row     <= row_sel(scan_row);
            dot_col     <= col_nxt;
            frame_start <= scan_fs;
            commit_ack  <= (state == SWAP);
            wr_ready    <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_dot_matrix_frame_ctrl.sv
// Self-checking bench for dot_matrix_frame_ctrl.
// Two instances (dwell 1 / dwell 4 + blank 1) against a frame-level model.
module tb_dot_matrix_frame_ctrl;

    logic       clock_div = 1'b0;
    logic       reset     = 1'b0;
    logic       wr_valid  = 1'b0;
    logic       commit    = 1'b0;
    logic [2:0] wr_row    = '0;
    logic [7:0] wr_data   = '0;

    logic       wr_ready_a, commit_ack_a, frame_start_a;
    logic [7:0] dot_row_a, dot_col_a;
    logic       wr_ready_b, commit_ack_b, frame_start_b;
    logic [7:0] dot_row_b, dot_col_b;

    always #5 clock_div = ~clock_div;

    dot_matrix_frame_ctrl #(
        .ROW_DWELL   (1),
        .BLANK_CYCLES(0)
    ) dut_a (
        .clock_div  (clock_div),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready_a),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .commit     (commit),
        .commit_ack (commit_ack_a),
        .frame_start(frame_start_a),
        .dot_row    (dot_row_a),
        .dot_col    (dot_col_a)
    );

    dot_matrix_frame_ctrl #(
        .ROW_DWELL   (4),
        .BLANK_CYCLES(1)
    ) dut_b (
        .clock_div  (clock_div),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready_b),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .commit     (commit),
        .commit_ack (commit_ack_b),
        .frame_start(frame_start_b),
        .dot_row    (dot_row_b),
        .dot_col    (dot_col_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Frame-level model: k counts edges since reset release, the
    // displayed position is p = k-1, a commit swaps at the first
    // frame boundary at least two edges after it was taken.
    int         dw [2];
    int         bl [2];
    int         k  [2];
    int         ck [2];
    bit         pend [2];
    logic [7:0] mback  [2][8];
    logic [7:0] mfront [2][8];
    logic       mwr [2];
    logic       mack [2];
    logic       mfs [2];
    logic [7:0] mrow [2];
    logic [7:0] mcol [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; ck[i] = 0; pend[i] = 0;
            mwr[i] = 0; mack[i] = 0; mfs[i] = 0;
            mrow[i] = 8'h00; mcol[i] = 8'h00;
            for (int r = 0; r < 8; r++) begin
                mback[i][r]  = 8'h00;
                mfront[i][r] = 8'h00;
            end
        end
    endtask

    task automatic model_edge(input int i);
        int         p;
        int         r;
        bit         fs;
        logic [7:0] top;
        top = 8'h80;
        if (mwr[i] && wr_valid) mback[i][wr_row] = wr_data;
        k[i]++;
        p  = k[i] - 1;
        fs = (p % (8 * dw[i])) == 0;
        mack[i] = 0;
        if (pend[i] && fs && k[i] >= ck[i] + 2) begin
            for (int j = 0; j < 8; j++) mfront[i][j] = mback[i][j];
            mack[i] = 1;
            pend[i] = 0;
        end else if (!pend[i] && commit) begin
            pend[i] = 1;
            ck[i]   = k[i];
        end
        mwr[i]  = !pend[i];
        r       = (p / dw[i]) % 8;
        mrow[i] = ~(top >> r);
        mcol[i] = ((p % dw[i]) < bl[i]) ? 8'h00 : mfront[i][r];
        mfs[i]  = fs;
    endtask

    task automatic compare();
        check("dot_row_a", dot_row_a, mrow[0]);
        check("dot_col_a", dot_col_a, mcol[0]);
        check("fs_a", frame_start_a, mfs[0]);
        check("ack_a", commit_ack_a, mack[0]);
        check("rdy_a", wr_ready_a, mwr[0]);
        check("dot_row_b", dot_row_b, mrow[1]);
        check("dot_col_b", dot_col_b, mcol[1]);
        check("fs_b", frame_start_b, mfs[1]);
        check("ack_b", commit_ack_b, mack[1]);
        check("rdy_b", wr_ready_b, mwr[1]);
    endtask

    task automatic step();
        @(posedge clock_div);
        if (reset) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clock_div);
        compare();
    endtask

    task automatic wait_row_a(input logic [7:0] sel);
        int n;
        n = 0;
        while (dot_row_a !== sel && n < 40) begin
            step();
            n++;
        end
        check("wait_row", dot_row_a, sel);
    endtask

    task automatic wait_ack_a();
        int n;
        n = 0;
        while (commit_ack_a !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        check("ack_seen", commit_ack_a, 1'b1);
    endtask

    logic [7:0] pat [8] = '{8'h18, 8'h24, 8'h42, 8'hC3,
                            8'h42, 8'h42, 8'h42, 8'h7E};

    initial begin
        int acks;
        int n;
        dw[0] = 1; bl[0] = 0;
        dw[1] = 4; bl[1] = 1;
        model_reset();
        repeat (2) @(negedge clock_div);
        compare();
        reset = 1'b1;

        step();
        check("first_row", dot_row_a, 8'h7F);
        check("first_fs", frame_start_a, 1'b1);
        check("first_col", dot_col_a, 8'h00);

        for (int r = 0; r < 8; r++) begin
            wr_valid = 1'b1;
            wr_row   = 3'(r);
            wr_data  = pat[r];
            step();
        end
        wr_valid = 1'b0;

        wait_row_a(8'hEF);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("rdy_drop", wr_ready_a, 1'b0);
        wait_ack_a();
        check("ack_fs", frame_start_a, 1'b1);
        check("ack_col", dot_col_a, 8'h18);
        step();
        check("row1_col", dot_col_a, 8'h24);

        wr_valid = 1'b1;
        wr_row   = 3'd2;
        wr_data  = 8'hFF;
        commit   = 1'b1;
        step();
        wr_valid = 1'b0;
        commit   = 1'b0;
        wait_ack_a();
        wait_row_a(8'hDF);
        check("wr_commit_col", dot_col_a, 8'hFF);

        commit = 1'b1;
        step();
        acks = 0;
        for (n = 0; n < 64; n++) begin
            wr_valid = 1'b1;
            wr_row   = 3'd5;
            wr_data  = 8'h00;
            commit   = n[0];
            step();
            if (commit_ack_a) begin
                acks++;
                break;
            end
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (commit_ack_a) acks++;
        end
        check("one_ack", 8'(acks), 8'd1);
        wait_row_a(8'hFB);
        check("pend_wr_ignored", dot_col_a, 8'h42);

        for (int j = 0; j < 1500; j++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            commit   = ($urandom_range(0, 15) == 0);
            step();
        end
        wr_valid = 1'b0;
        commit   = 1'b0;

        n = 0;
        while (wr_ready_a !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("idle_before_rst", wr_ready_a, 1'b1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        check("rst_row_a", dot_row_a, 8'h00);
        check("rst_col_a", dot_col_a, 8'h00);
        check("rst_rdy_a", wr_ready_a, 1'b0);
        check("rst_row_b", dot_row_b, 8'h00);
        model_reset();
        @(negedge clock_div);
        compare();
        reset = 1'b1;
        step();
        check("rel_rdy", wr_ready_a, 1'b1);
        check("rel_row", dot_row_a, 8'h7F);
        acks = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (commit_ack_a || commit_ack_b) acks++;
            check("blank_col_a", dot_col_a, 8'h00);
        end
        check("no_ack_after_rst", 8'(acks), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
